freq_meas_sequencer: RTL and testbench

FREQ_MEAS_SEQUENCER -- requirements
Module: freq_meas_sequencer

---
 rtl/freq_meas_sequencer_pkg.sv | 19 +
 rtl/freq_meas_sequencer_if.sv | 14 +
 rtl/freq_meas_sequencer_wb_single_master.sv | 61 ++++++
 rtl/freq_meas_sequencer.sv | 143 ++++++++++++++
 tb/tb_freq_meas_sequencer.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/freq_meas_sequencer_pkg.sv
// Shared constants for the frequency-measurement sequencer: counter-slave register
// map, control bit positions and the sequencer state encoding.
package freq_meas_pkg;
  localparam logic [31:0] ADDR_CTRL = 32'h8;
  localparam logic [31:0] ADDR_CNT  = 32'h9;
  localparam logic [31:0] ADDR_PH   = 32'hA;

  localparam int BIT_START = 7;
  localparam int BIT_DONE  = 6;
  localparam int BIT_READY = 5;
  localparam int BIT_RESET = 0;

  localparam logic [31:0] CTRL_RESET = 32'h1 << BIT_RESET;
  localparam logic [31:0] CTRL_START = 32'h1 << BIT_START;

  typedef enum logic [3:0] {
    IDLE, RST_WR, START_WR, POLL_WAIT, POLL_RD, CNT_RD, PH_RD, CLR_WR, DONE, ERR
  } state_t;
endpackage

// File: rtl/freq_meas_sequencer_if.sv
// Wishbone classic bus between the sequencer (master) and the counter slave.
interface freq_meas_sequencer_if;
  logic        cyc_o;
  logic        stb_o;
  logic        we_o;
  logic [31:0] addr_o;
  logic [31:0] dat_o;
  logic [3:0]  sel_o;
  logic [31:0] dat_i;
  logic        ack_i;

  modport master (output cyc_o, stb_o, we_o, addr_o, dat_o, sel_o, input dat_i, ack_i);
  modport slave  (input cyc_o, stb_o, we_o, addr_o, dat_o, sel_o, output dat_i, ack_i);
endinterface

// File: rtl/freq_meas_sequencer_wb_single_master.sv
// One Wishbone classic access per req; reports done (with read data) or ack timeout.
// The strobes drop on the edge that sees ack, so back-to-back accesses get a gap.
module wb_single_master #(
  parameter int ACK_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_dat,
  output logic        done,
  output logic        tmo,
  output logic [31:0] rdata,
  freq_meas_sequencer_if.master bus
);
  localparam int AW = $clog2(ACK_TIMEOUT + 1);

  logic [AW-1:0] ack_cnt;

  assign bus.sel_o = 4'hF;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.cyc_o  <= 1'b0;
      bus.stb_o  <= 1'b0;
      bus.we_o   <= 1'b0;
      bus.addr_o <= '0;
      bus.dat_o  <= '0;
      ack_cnt    <= '0;
      done       <= 1'b0;
      tmo        <= 1'b0;
      rdata      <= '0;
    end else begin
      done <= 1'b0;
      tmo  <= 1'b0;
      if (!bus.cyc_o) begin
        ack_cnt <= '0;
        if (req) begin
          bus.cyc_o  <= 1'b1;
          bus.stb_o  <= 1'b1;
          bus.we_o   <= req_we;
          bus.addr_o <= req_addr;
          bus.dat_o  <= req_dat;
        end
      end else if (bus.ack_i) begin
        bus.cyc_o <= 1'b0;
        bus.stb_o <= 1'b0;
        done      <= 1'b1;
        rdata     <= bus.dat_i;
      end else if (ack_cnt == AW'(ACK_TIMEOUT - 1)) begin
        // cyc held for exactly ACK_TIMEOUT cycles without ack
        bus.cyc_o <= 1'b0;
        bus.stb_o <= 1'b0;
        tmo       <= 1'b1;
      end else begin
        ack_cnt <= ack_cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/freq_meas_sequencer.sv
// Drives the counter slave through reset/start/poll/read/clear and publishes results.
// Optional FREQ_SEQ_CONTINUOUS_EN: DONE/ERR restart directly while start_i stays high.
module freq_meas_sequencer
  import freq_meas_pkg::*;
#(
  parameter int POLL_INTERVAL = 16,
  parameter int MEAS_TIMEOUT  = 1_000_000,
  parameter int ACK_TIMEOUT   = 64
) (
  input  logic        clk_i,
  input  logic        ext_rst_i,
  input  logic        start_i,
  output logic        busy_o,
  output logic        result_valid_o,
  output logic [31:0] count_o,
  output logic [7:0]  phase_o,
  output logic        timeout_o,
  freq_meas_sequencer_if.master wb
);
  localparam int PW = $clog2(POLL_INTERVAL + 1);
  localparam int MW = $clog2(MEAS_TIMEOUT + 1);

  state_t        state_q, state_d;
  logic          is_acc, req, req_we, launched_q;
  logic [31:0]   req_addr, req_dat, rdata;
  logic          acc_done, acc_tmo, restart;
  logic [PW-1:0] poll_cnt;
  logic [MW-1:0] meas_cnt;
  logic [31:0]   cnt_sh;
  logic [7:0]    ph_sh;
  logic          poll_end, meas_exp;

`ifdef FREQ_SEQ_CONTINUOUS_EN
  assign restart = start_i;
`else
  assign restart = 1'b0;
`endif

  assign poll_end       = (poll_cnt == PW'(POLL_INTERVAL - 1));
  assign meas_exp       = (meas_cnt == MW'(MEAS_TIMEOUT));
  assign busy_o         = (state_q != IDLE);
  assign result_valid_o = (state_q == DONE);
  assign req            = is_acc && !launched_q;

  wb_single_master #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_wb (
    .clk(clk_i), .rst_n(ext_rst_i), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_dat(req_dat), .done(acc_done), .tmo(acc_tmo), .rdata(rdata), .bus(wb)
  );

  always_comb begin
    state_d  = state_q;
    is_acc   = 1'b1;
    req_we   = 1'b0;
    req_addr = ADDR_CTRL;
    req_dat  = '0;
    case (state_q)
      IDLE: begin
        is_acc = 1'b0;
        if (start_i) state_d = RST_WR;
      end
      RST_WR: begin
        req_we  = 1'b1;
        req_dat = CTRL_RESET;
        if (acc_done) state_d = START_WR;
      end
      START_WR: begin
        req_we  = 1'b1;
        req_dat = CTRL_START;
        if (acc_done) state_d = POLL_WAIT;
      end
      POLL_WAIT: begin
        is_acc = 1'b0;
        if (meas_exp)      state_d = ERR;
        else if (poll_end) state_d = POLL_RD;
      end
      POLL_RD: begin
        // an in-flight poll is allowed to finish; a done flag wins over the timer
        if (acc_done) begin
          if (rdata[BIT_DONE]) state_d = CNT_RD;
          else if (meas_exp)   state_d = ERR;
          else                 state_d = POLL_WAIT;
        end
      end
      CNT_RD: begin
        req_addr = ADDR_CNT;
        if (acc_done) state_d = PH_RD;
      end
      PH_RD: begin
        req_addr = ADDR_PH;
        if (acc_done) state_d = CLR_WR;
      end
      CLR_WR: begin
        req_we = 1'b1;
        if (acc_done) state_d = DONE;
      end
      DONE: begin
        is_acc  = 1'b0;
        state_d = restart ? RST_WR : IDLE;
      end
      ERR: begin
        req_we  = 1'b1;
        req_dat = CTRL_RESET;
        if (acc_done || acc_tmo) state_d = restart ? RST_WR : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (is_acc && acc_tmo && state_q != ERR) state_d = ERR;
  end

  always_ff @(posedge clk_i or negedge ext_rst_i) begin
    if (!ext_rst_i) begin
      state_q    <= IDLE;
      launched_q <= 1'b0;
      poll_cnt   <= '0;
      meas_cnt   <= '0;
      cnt_sh     <= '0;
      ph_sh      <= '0;
      count_o    <= '0;
      phase_o    <= '0;
      timeout_o  <= 1'b0;
    end else begin
      state_q    <= state_d;
      launched_q <= (state_d == state_q) && (launched_q || req);

      if (state_q != POLL_WAIT || state_d != POLL_WAIT) poll_cnt <= '0;
      else if (!poll_end)                               poll_cnt <= poll_cnt + 1'b1;

      // runs from the first cycle after the start-write ack until the done flag
      if (state_q != POLL_WAIT && state_q != POLL_RD) meas_cnt <= '0;
      else if (!meas_exp)                             meas_cnt <= meas_cnt + 1'b1;

      if (state_q == CNT_RD && acc_done) cnt_sh <= rdata;
      if (state_q == PH_RD && acc_done)  ph_sh  <= rdata[7:0];
      if (state_d == DONE) begin
        count_o <= cnt_sh;
        phase_o <= ph_sh;
      end

      if (state_d == RST_WR && state_q != RST_WR) timeout_o <= 1'b0;
      else if (state_d == ERR && state_q != ERR)  timeout_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_freq_meas_sequencer.sv
// Bench for freq_meas_sequencer: counter-slave model with an expected-access queue,
// a vector table of normal runs, and hand-written timeout/reset/continuous sequences.
module tb_freq_meas_sequencer;
  logic        clk_i = 1'b0, ext_rst_i = 1'b1, start_i = 1'b0;
  logic        busy_o, result_valid_o, timeout_o;
  logic [31:0] count_o;
  logic [7:0]  phase_o;

  freq_meas_sequencer_if wb();

  freq_meas_sequencer #(.POLL_INTERVAL(4), .MEAS_TIMEOUT(200), .ACK_TIMEOUT(64)) dut (
    .clk_i(clk_i), .ext_rst_i(ext_rst_i), .start_i(start_i), .busy_o(busy_o),
    .result_valid_o(result_valid_o), .count_o(count_o), .phase_o(phase_o),
    .timeout_o(timeout_o), .wb(wb)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { bit we; logic [31:0] addr; logic [31:0] dat; } acc_t;
  typedef struct { int polls; logic [31:0] cnt; logic [7:0] ph; bit poke; } vec_t;

  acc_t        exp_q[$];
  vec_t        vt[4];
  int          total = 0, bad = 0;
  int          cyc_n = 0, rv_cnt = 0, rv0, n, d, extra;
  int          done_after = 0, polls_seen = 0, hold_cnt = 0, ack80_cyc = 0;
  logic [31:0] s_cnt = '0, prev_cnt = '0;
  logic [7:0]  s_ph = '0, prev_ph = '0;
  bit          loose = 0, hold80 = 0, in_acc = 0, hold = 0, found;

  always @(posedge clk_i) cyc_n <= cyc_n + 1;
  always @(posedge clk_i) begin
    #1;
    if (result_valid_o) rv_cnt = rv_cnt + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push(input bit we, input logic [31:0] a, input logic [31:0] dt);
    acc_t e;
    e.we = we; e.addr = a; e.dat = dt;
    exp_q.push_back(e);
  endtask

  task automatic push_run(input int polls);
    push(1, 32'h8, 32'h01);
    push(1, 32'h8, 32'h80);
    for (int k = 0; k <= polls; k++) push(0, 32'h8, 32'h0);
    push(0, 32'h9, 32'h0);
    push(0, 32'hA, 32'h0);
    push(1, 32'h8, 32'h00);
  endtask

  // counter-slave model: answers reads, checks each new access against the queue
  task automatic slave_access();
    acc_t e;
    hold = hold80 && wb.we_o && wb.dat_o == 32'h80;
    if (wb.we_o && wb.addr_o == 32'h8) begin
      if (wb.dat_o == 32'h01) polls_seen = 0;
      if (wb.dat_o == 32'h80) ack80_cyc = cyc_n;
    end
    if (!wb.we_o) begin
      case (wb.addr_o)
        32'h8: begin
          polls_seen++;
          wb.dat_i = (polls_seen > done_after) ? 32'h60 : 32'h20;
        end
        32'h9:   wb.dat_i = s_cnt;
        32'hA:   wb.dat_i = {24'hABCDEF, s_ph};
        default: wb.dat_i = 32'hDEADBEEF;
      endcase
    end
    if (loose && !wb.we_o && wb.addr_o == 32'h8) return;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL bus_unexpected: got we=%0d addr=%0h dat=%0h want no access",
               wb.we_o, wb.addr_o, wb.dat_o);
    end else begin
      e = exp_q.pop_front();
      if ({wb.we_o, wb.addr_o, (wb.we_o ? wb.dat_o : 32'h0), wb.sel_o} !==
          {e.we, e.addr, e.dat, 4'hF}) begin
        bad++;
        $display("FAIL bus_access: got we=%0d addr=%0h dat=%0h sel=%0h want we=%0d addr=%0h dat=%0h sel=f",
                 wb.we_o, wb.addr_o, wb.dat_o, wb.sel_o, e.we, e.addr, e.dat);
      end
    end
  endtask

  initial begin
    wb.ack_i = 1'b0;
    wb.dat_i = '0;
    forever begin
      @(negedge clk_i);
      if (wb.ack_i) wb.ack_i = 1'b0;
      else if (wb.cyc_o && wb.stb_o) begin
        if (!in_acc) begin
          in_acc = 1;
          slave_access();
        end
        if (hold) hold_cnt++;
        else begin
          wb.ack_i = 1'b1;
          in_acc   = 0;
        end
      end else in_acc = 0;
    end
  end

  task automatic pulse_start();
    @(negedge clk_i) start_i = 1'b1;
    @(negedge clk_i) start_i = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    done_after = v.polls; s_cnt = v.cnt; s_ph = v.ph;
    push_run(v.polls);
    pulse_start();
    chk("busy_on", busy_o, 1);
    chk("tmo_clear", timeout_o, 0);
    chk("hold_prev", {count_o, phase_o}, {prev_cnt, prev_ph});
    if (v.poke) begin
      repeat (5) @(negedge clk_i);
      pulse_start();
    end
    n = 0;
    while (!result_valid_o && n < 2000) begin
      @(negedge clk_i);
      n++;
    end
    chk("rv_seen", result_valid_o, 1);
    chk("count", count_o, v.cnt);
    chk("phase", phase_o, v.ph);
    @(negedge clk_i);
    chk("rv_pulse", result_valid_o, 0);
    chk("idle_after", busy_o, 0);
    extra = 0;
    repeat (20) @(negedge clk_i) if (result_valid_o) extra++;
    chk("single_rv", extra, 0);
    chk("queue_empty", exp_q.size(), 0);
    prev_cnt = v.cnt; prev_ph = v.ph;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ctl"}, {busy_o, result_valid_o, timeout_o, wb.cyc_o, wb.stb_o, wb.we_o}, 0);
    chk({tag, "_bus"}, {wb.addr_o, wb.dat_o}, 0);
    chk({tag, "_res"}, {count_o, phase_o}, 0);
  endtask

  task automatic wait_idle(input int bound);
    n = 0;
    while (busy_o && n < bound) begin
      @(negedge clk_i);
      n++;
    end
    chk("back_to_idle", busy_o, 0);
  endtask

  initial begin
    vt[0] = '{3, 32'h0000_1234, 8'h05, 1'b0};
    vt[1] = '{0, 32'hFFFF_FFFF, 8'hFF, 1'b0};
    vt[2] = '{1, 32'h0000_0000, 8'h00, 1'b1};
    vt[3] = '{5, 32'h8000_0001, 8'hA5, 1'b0};

    #2 ext_rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk_reset_vals("reset");
    ext_rst_i = 1'b1;
    @(negedge clk_i);

    for (int i = 0; i < 4; i++) run_vec(vt[i]);

    // done flag never rises: measurement timeout
    done_after = 100000; loose = 1; rv0 = rv_cnt;
    push(1, 32'h8, 32'h01); push(1, 32'h8, 32'h80); push(1, 32'h8, 32'h01);
    pulse_start();
    n = 0;
    while (!timeout_o && n < 1000) begin
      @(negedge clk_i);
      n++;
    end
    chk("meas_tmo", timeout_o, 1);
    d = cyc_n - ack80_cyc;
    chk("meas_tmo_time", (d >= 195 && d <= 215), 1);
    wait_idle(200);
    chk("meas_tmo_sticky", timeout_o, 1);
    chk("meas_no_rv", rv_cnt - rv0, 0);
    chk("meas_queue", exp_q.size(), 0);
    loose = 0;

    // ack withheld on the start write
    hold80 = 1; hold_cnt = 0; done_after = 0; rv0 = rv_cnt;
    push(1, 32'h8, 32'h01); push(1, 32'h8, 32'h80); push(1, 32'h8, 32'h01);
    pulse_start();
    wait_idle(300);
    chk("ack_tmo_cycles", hold_cnt, 64);
    chk("ack_tmo_flag", timeout_o, 1);
    chk("ack_no_rv", rv_cnt - rv0, 0);
    chk("ack_queue", exp_q.size(), 0);
    hold80 = 0;

    run_vec(vt[0]);

    // reset while a poll read is on the bus
    done_after = 100000; loose = 1;
    push(1, 32'h8, 32'h01); push(1, 32'h8, 32'h80);
    pulse_start();
    found = 0; n = 0;
    while (!found && n < 500) begin
      @(negedge clk_i);
      n++;
      if (wb.cyc_o && !wb.we_o && wb.addr_o == 32'h8) found = 1;
    end
    chk("found_poll", found, 1);
    ext_rst_i = 1'b0;
    #1;
    chk("rst_cyc_drop", {wb.cyc_o, wb.stb_o}, 0);
    chk_reset_vals("midrst");
    exp_q.delete();
    loose = 0;
    @(negedge clk_i) ext_rst_i = 1'b1;
    prev_cnt = '0; prev_ph = '0;
    @(negedge clk_i);
    run_vec(vt[3]);

`ifdef FREQ_SEQ_CONTINUOUS_EN
    // start held high: two runs back to back, each result followed by a fresh reset write
    done_after = 0; s_cnt = 32'h55; s_ph = 8'h66; rv0 = rv_cnt;
    push_run(0); push_run(0);
    @(negedge clk_i) start_i = 1'b1;
    n = 0;
    while (rv_cnt - rv0 < 2 && n < 500) begin
      @(negedge clk_i);
      n++;
    end
    start_i = 1'b0;
    wait_idle(100);
    chk("cont_rv_count", rv_cnt - rv0, 2);
    chk("cont_queue", exp_q.size(), 0);
    chk("cont_count", count_o, 32'h55);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1);
  end
endmodule
